// File: rtl/beeb_bus_responder.sv
// beeb_bus_responder: JIM-paged memory responder for an asynchronous 6502-style
// host bus. Phi2 is oversampled on the system clock. Each host cycle runs
// IDLE -> DECODE -> ACTIVE -> COMMIT. State changes only in COMMIT.
//
// Host handshake: a bus cycle starts on a synchronised phi2 rise and ends on a
// synchronised phi2 fall. Read data is driven while raw phi2 is high. Write
// data is the last data_in sampled while the first synchroniser stage was high.
module beeb_bus_responder #(
  parameter logic [7:0] DEV_ID = 8'hD1,
  parameter int         RAM_AW = 16,
  parameter int         NSYNC  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        phi2,
  input  logic [15:0] addr,
  input  logic        rnw,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        data_oe,
  output logic        selected,
  output logic [1:0]  dbg_state,
  output logic        dbg_abort
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DECODE = 2'd1,
    S_ACTIVE = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    C_NONE   = 3'd0,
    C_DEVSEL = 3'd1,
    C_PAGEHI = 3'd2,
    C_PAGELO = 3'd3,
    C_PTRLO  = 3'd4,
    C_PTRHI  = 3'd5,
    C_PORT   = 3'd6,
    C_WINDOW = 3'd7
  } cls_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                w_latch;
  logic                w_abort;

  logic [NSYNC-1:0]    r_sync;
  logic [NSYNC-1:0]    r_warm;
  logic                r_phi2_prev;
  logic                r_armed;
  logic                w_phi2_s;
  logic                w_rise;
  logic                w_fall;

  logic [15:0]         r_addr;
  logic                r_rnw;
  cls_t                r_cls;
  cls_t                w_cls;
  logic                r_resp;
  logic                w_resp;

  logic [7:0]          r_wcap;
  logic                r_selected;
  logic [15:0]         r_page;
  logic [RAM_AW-1:0]   r_ptr;
  logic [15:0]         w_ptr16;

  logic [7:0]          r_mem [2**RAM_AW];
  logic [7:0]          r_ram_q;
  logic [RAM_AW-1:0]   w_win_addr;
  logic [RAM_AW-1:0]   w_rd_addr;
  logic [RAM_AW-1:0]   w_wr_addr;
  logic                w_commit_wr;
  logic                w_ram_we;

  logic [7:0]          r_dout;
  logic [7:0]          w_dout_nxt;
  logic                r_dvld;
  logic                r_abort;

  // Phi2 synchroniser plus a warm-up chain so a phi2 already high at reset
  // release is never mistaken for a rise.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync      <= '0;
      r_warm      <= '0;
      r_phi2_prev <= 1'b0;
      r_armed     <= 1'b0;
    end else begin
      r_sync      <= {r_sync[NSYNC-2:0], phi2};
      r_warm      <= {r_warm[NSYNC-2:0], 1'b1};
      r_phi2_prev <= w_phi2_s;
      r_armed     <= r_armed | (r_warm[NSYNC-1] & ~w_phi2_s);
    end
  end

  assign w_phi2_s = r_sync[NSYNC-1];
  assign w_rise   = r_armed & w_phi2_s & ~r_phi2_prev;
  assign w_fall   = ~w_phi2_s & r_phi2_prev;

  // FSM state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // FSM next-state: latch strobe on every accepted rise, abort on a rise in ACTIVE.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_state_nxt = S_DECODE;
          w_latch     = 1'b1;
        end
      end
      S_DECODE: w_state_nxt = S_ACTIVE;
      S_ACTIVE: begin
        if (w_rise) begin
          w_state_nxt = S_DECODE;
          w_latch     = 1'b1;
          w_abort     = 1'b1;
        end else if (w_fall) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Address classification; paged registers only exist while selected.
  always_comb begin
    w_cls = C_NONE;
    if (r_addr == 16'hFCFF) begin
      w_cls = C_DEVSEL;
    end else if (r_selected) begin
      if (r_addr == 16'hFCFD)            w_cls = C_PAGEHI;
      else if (r_addr == 16'hFCFE)       w_cls = C_PAGELO;
      else if (r_addr == 16'hFC80)       w_cls = C_PTRLO;
      else if (r_addr == 16'hFC81)       w_cls = C_PTRHI;
      else if (r_addr == 16'hFC82)       w_cls = C_PORT;
      else if (r_addr[15:8] == 8'hFD)    w_cls = C_WINDOW;
      else                               w_cls = C_NONE;
    end
  end

  assign w_resp = (w_cls != C_NONE) && (w_cls != C_DEVSEL);

  // Latch the host address phase and the decode result.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_addr <= 16'h0000;
      r_rnw  <= 1'b0;
      r_cls  <= C_NONE;
      r_resp <= 1'b0;
    end else begin
      if (w_latch) begin
        r_addr <= addr;
        r_rnw  <= rnw;
      end
      if (r_state == S_DECODE) begin
        r_cls  <= w_cls;
        r_resp <= w_resp;
      end
    end
  end

  // Write capture follows data_in while the first synchroniser stage is high.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)          r_wcap <= 8'h00;
    else if (r_sync[0]) r_wcap <= data_in;
  end

  assign w_ptr16     = 16'(r_ptr);
  assign w_win_addr  = RAM_AW'({r_page, r_addr[7:0]});
  assign w_rd_addr   = (r_addr == 16'hFC82) ? r_ptr : w_win_addr;
  assign w_wr_addr   = (r_cls == C_PORT) ? r_ptr : w_win_addr;
  assign w_commit_wr = (r_state == S_COMMIT) && !r_rnw;
  assign w_ram_we    = w_commit_wr && ((r_cls == C_PORT) || (r_cls == C_WINDOW));

  // Register file updates happen only in COMMIT; the port auto-increments on any access.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_selected <= 1'b0;
      r_page     <= 16'h0000;
      r_ptr      <= '0;
    end else if (r_state == S_COMMIT) begin
      if (!r_rnw) begin
        case (r_cls)
          C_DEVSEL: r_selected  <= (r_wcap == DEV_ID);
          C_PAGEHI: r_page[15:8] <= r_wcap;
          C_PAGELO: r_page[7:0]  <= r_wcap;
          C_PTRLO:  r_ptr <= RAM_AW'({w_ptr16[15:8], r_wcap});
          C_PTRHI:  r_ptr <= RAM_AW'({r_wcap, w_ptr16[7:0]});
          default:  ;
        endcase
      end
      if (r_cls == C_PORT) r_ptr <= r_ptr + RAM_AW'(1);
    end
  end

  // Paged RAM: synchronous read issued in DECODE, write in COMMIT; not reset.
  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_wr_addr] <= r_wcap;
    if (r_state == S_DECODE) r_ram_q <= r_mem[w_rd_addr];
  end

  // Read data source selection.
  always_comb begin
    w_dout_nxt = 8'h00;
    case (r_cls)
      C_PORT, C_WINDOW: w_dout_nxt = r_ram_q;
      C_PAGEHI:         w_dout_nxt = r_page[15:8];
      C_PAGELO:         w_dout_nxt = r_page[7:0];
      C_PTRLO:          w_dout_nxt = w_ptr16[7:0];
      C_PTRHI:          w_dout_nxt = w_ptr16[15:8];
      default:          w_dout_nxt = 8'h00;
    endcase
  end

  // Read data register: valid from the second clock after DECODE entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_dout  <= 8'h00;
      r_dvld  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      if (r_state == S_ACTIVE) r_dout <= w_dout_nxt;
      r_dvld  <= (r_state == S_ACTIVE);
      r_abort <= r_abort | w_abort;
    end
  end

  // Raw phi2 gates the drive enable so the bus is released at the phi2 fall.
  assign data_oe   = r_rnw & r_resp & (r_state == S_ACTIVE) & r_dvld & phi2;
  assign data_out  = r_dout;
  assign selected  = r_selected;
  assign dbg_state = r_state;
  assign dbg_abort = r_abort;

endmodule
